seg7_scan_driver: RTL



---
 rtl/seg7_scan_driver.sv | 135 +++++++++++++
 1 files changed

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed common-anode 7-segment driver: shadow-latched nibbles, per-slot blanking, BCD/hex decode.
// Optional leading-zero blanking is compiled in by defining SEG7_SCAN_LZB_EN.
module seg7_scan_driver #(
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int BLANK_CYC   = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [4*DIGITS-1:0] value,
  input  logic                load,
  input  logic                hex_mode,
  input  logic                blank_lz,
  output logic [6:0]          seg,
  output logic [DIGITS-1:0]   an,
  output logic                frame_done
);

  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] CNT_SHOW = CW'(BLANK_CYC);
  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);
  localparam logic [6:0]    SEG_OFF  = 7'b1111111;

  logic [4*DIGITS-1:0] r_shadow;
  logic [CW-1:0]       r_cnt;
  logic [IW-1:0]       r_idx;
  logic [6:0]          r_seg;
  logic [DIGITS-1:0]   r_an;
  logic                r_frame;

  logic [3:0]          w_nibble;
  logic                w_suppress;
  logic                w_cnt_wrap;
  logic [6:0]          w_seg_nxt;
  logic [DIGITS-1:0]   w_an_nxt;
  logic                w_frame_nxt;

  // Segment patterns are active-low {g,f,e,d,c,b,a}; letters only when hex is enabled.
  function automatic logic [6:0] f_decode(input logic [3:0] nib, input logic hex);
    logic [6:0] pat;
    pat = SEG_OFF;
    case (nib)
      4'h0: pat = 7'b1000000;
      4'h1: pat = 7'b1111001;
      4'h2: pat = 7'b0100100;
      4'h3: pat = 7'b0110000;
      4'h4: pat = 7'b0011001;
      4'h5: pat = 7'b0010010;
      4'h6: pat = 7'b0000010;
      4'h7: pat = 7'b1111000;
      4'h8: pat = 7'b0000000;
      4'h9: pat = 7'b0010000;
      4'hA: pat = hex ? 7'b0001000 : SEG_OFF;
      4'hB: pat = hex ? 7'b0000011 : SEG_OFF;
      4'hC: pat = hex ? 7'b1000110 : SEG_OFF;
      4'hD: pat = hex ? 7'b0100001 : SEG_OFF;
      4'hE: pat = hex ? 7'b0000110 : SEG_OFF;
      4'hF: pat = hex ? 7'b0001110 : SEG_OFF;
      default: pat = SEG_OFF;
    endcase
    return pat;
  endfunction

  assign w_cnt_wrap = (r_cnt == CNT_LAST);

  always_comb begin
    w_nibble = 4'h0;
    for (int i = 0; i < DIGITS; i++) begin
      if (r_idx == IW'(i)) w_nibble = r_shadow[4*i +: 4];
    end
  end

`ifdef SEG7_SCAN_LZB_EN
  // w_zero_above[k]: nibble k and every higher nibble are zero.
  logic [DIGITS-1:0] w_zero_above;
  for (genvar k = 0; k < DIGITS; k++) begin : g_lz
    assign w_zero_above[k] = ~|r_shadow[4*DIGITS-1:4*k];
  end
  assign w_suppress = blank_lz && (r_idx != '0) && w_zero_above[r_idx];
`else
  logic w_unused_blank_lz;
  assign w_unused_blank_lz = blank_lz;
  assign w_suppress        = 1'b0;
`endif

  always_comb begin
    w_seg_nxt   = SEG_OFF;
    w_an_nxt    = '1;
    w_frame_nxt = w_cnt_wrap && (r_idx == IDX_LAST);
    if ((r_cnt >= CNT_SHOW) && !w_suppress) begin
      w_an_nxt  = ~({{(DIGITS-1){1'b0}}, 1'b1} << r_idx);
      w_seg_nxt = f_decode(w_nibble, hex_mode);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shadow <= '0;
    end else if (load) begin
      r_shadow <= value;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_idx <= '0;
    end else if (w_cnt_wrap) begin
      r_cnt <= '0;
      r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Outputs are registered from the pre-edge scan state, so pins lag cnt/idx by one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seg   <= SEG_OFF;
      r_an    <= '1;
      r_frame <= 1'b0;
    end else begin
      r_seg   <= w_seg_nxt;
      r_an    <= w_an_nxt;
      r_frame <= w_frame_nxt;
    end
  end

  assign seg        = r_seg;
  assign an         = r_an;
  assign frame_done = r_frame;

endmodule
